mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_BUS_WIDTH, default 8, width of write/read data.
REQ-002 Parameter ADDRESS_WIDTH, default 16, width of request address.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles to wait for mem_op_done; legal range 1..255.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 req  input  2  per-requester request level; bit 0 = ctrl, bit 1 = host loader.
REQ-007 req_op  input  2x mem_req_op_e  per-requester operation, held stable while req is high.
REQ-008 req_addr  input  2xADDRESS_WIDTH  per-requester address, held stable while req is high.
REQ-009 req_wdata  input  2xDATA_BUS_WIDTH  per-requester write data, held stable while req is high.
REQ-010 grant  output  2  one-hot owner of the memory unit; 0 when idle.
REQ-011 done  output  2  one-cycle completion pulse to the owner.
REQ-012 err  output  1  valid with done; 1 = transaction timed out.
REQ-013 rdata  output  DATA_BUS_WIDTH  read result, valid only while done is high.
REQ-014 mem_op  output  mem_req_op_e  operation driven to the memory unit.
REQ-015 mem_addr  output  ADDRESS_WIDTH  latched address to the memory unit.
REQ-016 mem_wdata  output  DATA_BUS_WIDTH  latched write data to the memory unit.
REQ-017 mem_op_done  input  1  memory unit completion strobe.
REQ-018 mem_rdata  input  DATA_BUS_WIDTH  memory unit read data, valid with mem_op_done.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-020 IDLE: on a rising edge with any req bit high, the arbiter SHALL select one requester, latch its op/addr/wdata into mem_* registers, set grant, clear the timeout counter and enter BUSY.
REQ-021 A request with req_op = REQ_NOP SHALL be granted and completed in DONE with err=0 and rdata=0, without driving mem_op.
REQ-022 Selection SHALL be round-robin: with both requests high, the requester not granted last wins; with one high, it wins.
REQ-023 BUSY: mem_op SHALL equal the latched op; the counter SHALL increment each cycle.
REQ-024 BUSY: mem_op_done high SHALL capture mem_rdata into rdata, set err=0 and enter DONE.
REQ-025 BUSY: counter reaching TIMEOUT_CYCLES without mem_op_done SHALL set err=1, rdata=all-ones and enter DONE; mem_op_done on that same cycle takes precedence (normal completion).
REQ-026 DONE: mem_op SHALL be REQ_NOP; done SHALL pulse for exactly one cycle on the granted bit; last-grant pointer SHALL update; next state IDLE with grant=0.
REQ-027 Minimum latency: req seen at edge 0, mem_op active in cycle 1, mem_op_done in cycle 1 gives done in cycle 2; back-to-back service of the other requester begins mem_op in cycle 4.
REQ-028 Requesters SHALL drop req at the edge ending their done cycle; req high in IDLE is always a new request.
REQ-029 req deasserted during BUSY SHALL NOT abort; the transaction completes and done still pulses.
REQ-030 Changes on req_op/req_addr/req_wdata after the latch edge SHALL NOT affect mem_* outputs.
REQ-031 mem_op_done outside BUSY SHALL be ignored.

Reset
REQ-032 Reset assertion SHALL, without a clock, force state IDLE, grant=0, done=0, err=0, rdata=0, mem_op=REQ_NOP, mem_addr=0, mem_wdata=0, counter=0, last-grant=1 (ctrl wins first).
REQ-033 Reset mid-transaction SHALL drop the transaction with no done pulse.

Structure
REQ-034 mem_req_op_e (REQ_NOP=2'b00, REQ_READ=2'b01, REQ_WRITE=2'b10) and arb_state_e SHALL live in the shared package.
REQ-035 The timeout counter SHALL be a sub-module mem_arb_timer (clear, enable, expired).

Verification
REQ-036 Single read: req=01, op READ, addr 0x1234, mem_op_done after 3 cycles with mem_rdata 0x5A -> mem_addr=0x1234, done=01, rdata=0x5A, err=0.
REQ-037 Contention: req=11 from reset -> ctrl served first, host second; repeated req=11 alternates 01,10,01.
REQ-038 Timeout: TIMEOUT_CYCLES=4, no mem_op_done -> done pulses 5 cycles after BUSY entry, err=1, rdata=0xFF, mem_op back to NOP.
REQ-039 Write with input change: host WRITE 0xBEEF/0x33, req_wdata changed to 0x00 during BUSY -> mem_wdata stays 0x33.
REQ-040 Reset in BUSY: assert reset two cycles into a read -> all outputs zero immediately, no done pulse; next req=11 grants ctrl.
REQ-041 Done/timeout collision: mem_op_done on the timeout cycle -> err=0, rdata=mem_rdata.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared operation/state types and timer width for the memory arbiter
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    REQ_NOP   = 2'b00,
    REQ_READ  = 2'b01,
    REQ_WRITE = 2'b10
  } mem_req_op_e;
  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_e;
  localparam int TIMER_WIDTH = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-unit bus of the arbiter
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16
);
  logic [1:0]                          req;
  mem_req_op_e [1:0]                   req_op;
  logic [1:0][ADDRESS_WIDTH-1:0]       req_addr;
  logic [1:0][DATA_BUS_WIDTH-1:0]      req_wdata;
  logic [1:0]                          grant;
  logic [1:0]                          done;
  logic                                err;
  logic [DATA_BUS_WIDTH-1:0]           rdata;
  mem_req_op_e                         mem_op;
  logic [ADDRESS_WIDTH-1:0]            mem_addr;
  logic [DATA_BUS_WIDTH-1:0]           mem_wdata;
  logic                                mem_op_done;
  logic [DATA_BUS_WIDTH-1:0]           mem_rdata;
  modport slave (
    input  req, req_op, req_addr, req_wdata, mem_op_done, mem_rdata,
    output grant, done, err, rdata, mem_op, mem_addr, mem_wdata
  );
  modport master (
    output req, req_op, req_addr, req_wdata, mem_op_done, mem_rdata,
    input  grant, done, err, rdata, mem_op, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: cycle counter that flags when a memory transaction has waited too long
module mem_arb_timer
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [TIMER_WIDTH-1:0] cnt_q, cnt_d;
  // clear wins over counting so a new transaction always starts from zero
  always_comb cnt_d = clear ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = enable && (cnt_q == TIMER_WIDTH'(TIMEOUT_CYCLES));
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter granting one of two requesters access to a memory unit
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         clk,
  input logic         rst_n,
  mem_arbiter_if.slave bus
);
  arb_state_e                state_q, state_d;
  logic [1:0]                grant_q, grant_d;
  logic                      last_q, last_d;
  mem_req_op_e               op_q, op_d;
  logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_BUS_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      sel, clear, busy, expired;
  assign sel  = (&bus.req) ? ~last_q : bus.req[1];
  assign busy = (state_q == BUSY);
  mem_arb_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .enable (busy),
    .expired(expired)
  );
  // next-state: latch a request, wait for completion or timeout, then pulse done
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    clear   = 1'b0;
    case (state_q)
      IDLE: if (|bus.req) begin
        grant_d = sel ? 2'b10 : 2'b01;
        op_d    = bus.req_op[sel];
        addr_d  = bus.req_addr[sel];
        wdata_d = bus.req_wdata[sel];
        rdata_d = '0;
        err_d   = 1'b0;
        clear   = 1'b1;
        state_d = (bus.req_op[sel] == REQ_NOP) ? DONE : BUSY;
      end
      BUSY: if (bus.mem_op_done) begin
        rdata_d = bus.mem_rdata;
        err_d   = 1'b0;
        state_d = DONE;
      end else if (expired) begin
        rdata_d = '1;
        err_d   = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        last_d  = grant_q[1];
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and latched transaction registers; last-grant resets to host so ctrl wins first
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 1'b1;
      op_q    <= REQ_NOP;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  assign bus.grant     = grant_q;
  assign bus.done      = (state_q == DONE) ? grant_q : 2'b00;
  assign bus.err       = (state_q == DONE) & err_q;
  assign bus.rdata     = (state_q == DONE) ? rdata_q : '0;
  assign bus.mem_op    = busy ? op_q : REQ_NOP;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for the round-robin memory arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int T  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_BUS_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();
  mem_arbiter #(.DATA_BUS_WIDTH(DW), .ADDRESS_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          who;
    mem_req_op_e   op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
    logic          drop;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t rst_e;
  int total = 0;
  int bad = 0;
  int last_who = 1;
  int bcnt = 0;
  int rk = 0;

  mem_req_op_e   op_a[2];
  logic [AW-1:0] addr_a[2];
  logic [DW-1:0] wd_a[2];
  logic [DW-1:0] rd_a[2];
  int            d_a[2];
  int            resp_d[2];
  logic [DW-1:0] resp_rd[2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of one request from its op and the memory's response delay
  // (d = busy cycles before mem_op_done, -1 = never answers).
  function automatic exp_t model(int b);
    exp_t e;
    e.who = b[0];
    e.op = op_a[b];
    e.addr = addr_a[b];
    e.wdata = wd_a[b];
    e.drop = 1'b0;
    if (op_a[b] == REQ_NOP) begin
      e.err = 1'b0; e.rdata = '0; e.lat = 0;
    end else if (d_a[b] >= 0 && d_a[b] <= T) begin
      e.err = 1'b0; e.rdata = rd_a[b]; e.lat = d_a[b] + 1;
    end else begin
      e.err = 1'b1; e.rdata = '1; e.lat = T + 1;
    end
    return e;
  endfunction

  task automatic set_req(int b, mem_req_op_e op, logic [AW-1:0] a, logic [DW-1:0] w, int d, logic [DW-1:0] r);
    op_a[b] = op; addr_a[b] = a; wd_a[b] = w; d_a[b] = d; rd_a[b] = r;
  endtask

  task automatic rand_req(int b);
    int r;
    r = int'($urandom_range(0, 9));
    op_a[b] = mem_req_op_e'($urandom_range(0, 2));
    addr_a[b] = AW'($urandom);
    wd_a[b] = DW'($urandom);
    rd_a[b] = DW'($urandom);
    if (r < 6) d_a[b] = int'($urandom_range(0, 3));
    else if (r == 6) d_a[b] = T;
    else if (r == 7) d_a[b] = T + 1;
    else if (r == 8) d_a[b] = -1;
    else d_a[b] = int'($urandom_range(0, T - 1));
  endtask

  task automatic drive(int b);
    bus.req_op[b] = op_a[b];
    bus.req_addr[b] = addr_a[b];
    bus.req_wdata[b] = wd_a[b];
    resp_d[b] = d_a[b];
    resp_rd[b] = rd_a[b];
  endtask

  // Issue one round; with both requesting, the one not served last goes first.
  task automatic run(logic [1:0] pat);
    int first;
    int n;
    if (pat == 2'b11) begin
      first = last_who ? 0 : 1;
      sb.push_back(model(first));
      sb.push_back(model(1 - first));
      last_who = 1 - first;
    end else begin
      first = pat[1] ? 1 : 0;
      sb.push_back(model(first));
      last_who = first;
    end
    @(negedge clk);
    for (int b = 0; b < 2; b++) if (pat[b]) drive(b);
    bus.req = pat;
    n = 0;
    while (bus.req != 2'b00) begin
      @(negedge clk);
      for (int b = 0; b < 2; b++)
        if (bus.done[b]) bus.req[b] = 1'b0;
        else if (bus.grant[b]) begin
          bus.req_wdata[b] = '0;
          bus.req_addr[b] = ~addr_a[b];
        end
      n++;
      if (n > 100) begin
        $display("FAIL round_timeout: req still %b after 100 cycles, want all served", bus.req);
        $fatal(1, "round did not complete");
      end
    end
  endtask

  // Memory unit model: answers after resp_d busy cycles, and toggles
  // mem_op_done randomly whenever no operation is active.
  initial begin
    bus.mem_op_done = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_op != REQ_NOP) begin
        bus.mem_op_done = (rk == resp_d[bus.grant[1]]);
        bus.mem_rdata = bus.mem_op_done ? resp_rd[bus.grant[1]] : DW'($urandom);
        rk++;
      end else begin
        rk = 0;
        bus.mem_op_done = 1'($urandom_range(0, 1));
        bus.mem_rdata = DW'($urandom);
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard head
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      bcnt = 0;
      if (sb.size() > 0 && sb[0].drop) void'(sb.pop_front());
      check("rst_grant", bus.grant, 0);
      check("rst_done", bus.done, 0);
      check("rst_err", bus.err, 0);
      check("rst_rdata", bus.rdata, 0);
      check("rst_mem_op", bus.mem_op, REQ_NOP);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
    end else if (bus.done != 2'b00) begin
      if (sb.size() == 0) check("unexpected_done", bus.done, 0);
      else begin
        mon_e = sb.pop_front();
        if (mon_e.drop) check("dropped_done", bus.done, 0);
        else begin
          check("done_bit", bus.done, mon_e.who ? 2 : 1);
          check("done_grant", bus.grant, mon_e.who ? 2 : 1);
          check("done_err", bus.err, mon_e.err);
          check("done_rdata", bus.rdata, mon_e.rdata);
          check("done_mem_op", bus.mem_op, REQ_NOP);
          check("done_mem_addr", bus.mem_addr, mon_e.addr);
          check("done_mem_wdata", bus.mem_wdata, mon_e.wdata);
          check("done_latency", bcnt, mon_e.lat);
        end
      end
      bcnt = 0;
    end else if (bus.grant != 2'b00) begin
      if (sb.size() == 0) check("unexpected_grant", bus.grant, 0);
      else begin
        check("busy_grant", bus.grant, sb[0].who ? 2 : 1);
        check("busy_mem_op", bus.mem_op, sb[0].op);
      end
      bcnt++;
    end else check("idle_mem_op", bus.mem_op, REQ_NOP);
  end

  initial begin
    int n;
    bus.req = 2'b00;
    for (int b = 0; b < 2; b++) begin
      bus.req_op[b] = REQ_NOP;
      bus.req_addr[b] = '0;
      bus.req_wdata[b] = '0;
      resp_d[b] = -1;
      resp_rd[b] = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // contention from reset: ctrl, host, ctrl, host
    set_req(0, REQ_READ, 16'h0100, 8'h11, 1, 8'hA1);
    set_req(1, REQ_WRITE, 16'h0200, 8'h22, 0, 8'hB2);
    run(2'b11);
    run(2'b11);
    // single read
    set_req(0, REQ_READ, 16'h1234, 8'h00, 3, 8'h5A);
    run(2'b01);
    // timeout with no response
    set_req(0, REQ_READ, 16'h0BAD, 8'h00, -1, 8'h00);
    run(2'b01);
    // host write; inputs scrambled during busy
    set_req(1, REQ_WRITE, 16'hBEEF, 8'h33, 2, 8'h44);
    run(2'b10);
    // response on the timeout cycle
    set_req(1, REQ_READ, 16'h0C0D, 8'h00, T, 8'hC3);
    run(2'b10);
    // NOP request
    set_req(0, REQ_NOP, 16'h5555, 8'hAA, 0, 8'h99);
    run(2'b01);
    // reset two cycles into a read
    set_req(0, REQ_READ, 16'h4321, 8'h77, -1, 8'h00);
    rst_e = model(0);
    rst_e.drop = 1'b1;
    sb.push_back(rst_e);
    @(negedge clk);
    drive(0);
    bus.req = 2'b01;
    n = 0;
    while (!bus.grant[0]) begin
      @(negedge clk);
      n++;
      if (n > 20) begin
        $display("FAIL reset_grant_timeout: grant %b, want 01", bus.grant);
        $fatal(1, "no grant");
      end
    end
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    bus.req = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_who = 1;
    set_req(0, REQ_READ, 16'h0A0A, 8'h01, 0, 8'h3C);
    set_req(1, REQ_READ, 16'h0B0B, 8'h02, 1, 8'hC4);
    run(2'b11);
    // randomized rounds
    for (int i = 0; i < 60; i++) begin
      rand_req(0);
      rand_req(1);
      run(2'($urandom_range(1, 3)));
    end
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL drain: %0d expected responses outstanding, want 0", sb.size());
        $fatal(1, "scoreboard not drained");
      end
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
